fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queue entries; legal values are powers of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h00000000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  redirect request from the execute-stage branch decision.
REQ-006 flushTarget  input  32  redirect address.
REQ-007 memAddress  output  32  instruction memory address, equal to the internal fetch PC.
REQ-008 memRequest  output  1  high when the queue can accept a fetched word.
REQ-009 memSuccess  input  1  combinational success from instruction memory for the current memAddress.
REQ-010 memData  input  32  instruction word for memAddress, valid when memSuccess is high.
REQ-011 consumerReady  input  1  high when the IF/ID barrier accepts an instruction this cycle, i.e. the pipeline is not stalled.
REQ-012 outValid  output  1  head entry is valid.
REQ-013 outInstruction  output  32  head instruction; NOP 32'h00000013 when outValid is low.
REQ-014 outProgramCounter  output  32  PC of the head instruction; 0 when outValid is low.

Function
REQ-015 The queue SHALL be a circular buffer of DEPTH {pc, instruction} entries, with a read pointer, a write pointer and a count of width clog2(DEPTH)+1.
REQ-016 memRequest SHALL equal (count != DEPTH); a full queue SHALL block a push even when a pop occurs in the same cycle.
REQ-017 Push condition: memRequest && memSuccess && !flush; it SHALL write {fetchPc, memData} at the write pointer and advance fetchPc by 4 with modulo-2^32 wrap.
REQ-018 Pop condition: outValid && consumerReady && !flush; it SHALL advance the read pointer.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 Head outputs SHALL be combinational from the read pointer, so a pushed entry appears at the outputs on the cycle after the push (latency 1 cycle, empty to outValid).
REQ-022 When memSuccess is low, fetchPc and the queue SHALL hold, and memAddress SHALL remain stable until success.
REQ-023 flush SHALL take priority over push and pop: count becomes 0, both pointers become 0, and fetchPc becomes {flushTarget[31:2], 2'b00}; outValid SHALL be low on the next cycle.
REQ-024 A flush with memSuccess high in the same cycle SHALL discard that fetched word.
REQ-025 When outValid is low, consumerReady SHALL have no effect.

Reset
REQ-026 While rst is high: fetchPc = RESET_PC, count = 0, pointers = 0, outValid = 0, outInstruction = 32'h00000013, outProgramCounter = 0, memAddress = RESET_PC, memRequest = 1.
REQ-027 Reset SHALL override flush and any in-progress push or pop; an assertion in the middle of operation SHALL discard all entries asynchronously.
REQ-028 Entry storage contents need no reset, because outputs are masked by outValid.

Structure
REQ-029 The NOP encoding (32'h00000013), the PC increment (4) and the default DEPTH SHALL live in the shared CPU constants package/header.
REQ-030 Entry storage SHALL be a sub-module, fetch_queue_ram: DEPTH x 64 bits, synchronous write, asynchronous read. Pointer, count and fetchPc logic SHALL remain in fetch_queue.

Verification
REQ-031 Scenario: reset, then memSuccess=1 and consumerReady=0 for 6 cycles -> 4 pushes at PCs 0, 4, 8, 12; memRequest=0 from cycle 4; memAddress holds at 16.
REQ-032 Scenario: full queue, consumerReady=1 for one cycle -> pop of PC 0, no push that cycle; the next cycle pushes PC 16.
REQ-033 Scenario: steady state with memSuccess=1 and consumerReady=1 -> one instruction per cycle, outProgramCounter increments by 4, count constant.
REQ-034 Scenario: memSuccess=0 for 3 cycles at memAddress 8 -> no push and memAddress stays at 8; PC 8 is pushed on the first success.
REQ-035 Scenario: 3 entries queued, flush with flushTarget=32'h00000102 and memSuccess=1 -> the next cycle has outValid=0 and memAddress=32'h00000100; the fetched word is discarded.
REQ-036 Scenario: fetchPc=32'hFFFFFFFC push -> next memAddress=0 (wrap); rst pulsed with 2 entries queued -> outValid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared CPU fetch constants and types: the NOP encoding, the PC step,
// the default queue depth and the {pc, instruction} entry layout.
package fetch_queue_pkg;

  typedef logic [31:0] word_t;

  localparam word_t       NOP_INSTR     = 32'h0000_0013;
  localparam word_t       PC_INCR       = 32'h0000_0004;
  localparam int unsigned DEFAULT_DEPTH = 32'd4;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fq_entry_t;

  // Redirect targets are word aligned; the low two bits are dropped.
  function automatic word_t align_pc(input word_t pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction memory side and IF/ID consumer side.
// master = fetch_queue, slave = memory plus pipeline environment.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  word_t memAddress;
  logic  memRequest;
  logic  memSuccess;
  word_t memData;
  logic  consumerReady;
  logic  outValid;
  word_t outInstruction;
  word_t outProgramCounter;

  modport master (
    output memAddress, memRequest, outValid, outInstruction, outProgramCounter,
    input  memSuccess, memData, consumerReady
  );

  modport slave (
    input  memAddress, memRequest, outValid, outInstruction, outProgramCounter,
    output memSuccess, memData, consumerReady
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// Fetch queue entry storage: DEPTH x 64-bit, synchronous write, asynchronous read.
// Contents are not reset; the head outputs are masked by outValid.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fq_entry_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output fq_entry_t     rd_data
);

  fq_entry_t mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetch PC, circular-buffer pointers and count,
// with flush redirect and combinational head outputs.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter word_t       RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  word_t         flushTarget,
  fetch_queue_if.master bus
);

  localparam int unsigned   AW         = $clog2(DEPTH);
  localparam int unsigned   CW         = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  word_t         fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic      mem_request_s;
  logic      out_valid_s;
  logic      push_s;
  logic      pop_s;
  fq_entry_t wr_entry_s;
  fq_entry_t head_s;

  // A full queue refuses a push even if a pop frees a slot this cycle.
  assign mem_request_s = (count_q != FULL_COUNT);
  assign out_valid_s   = (count_q != {CW{1'b0}});
  assign push_s        = mem_request_s && bus.memSuccess && !flush;
  assign pop_s         = out_valid_s && bus.consumerReady && !flush;
  assign wr_entry_s    = '{pc: fetch_pc_q, instr: bus.memData};

  // Next-state for fetch PC, pointers and count; flush wins over push/pop
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (flush) begin
      fetch_pc_d = align_pc(flushTarget);
      rd_ptr_d   = {AW{1'b0}};
      wr_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + PC_INCR;
      end else begin
        wr_ptr_d   = wr_ptr_q;
        fetch_pc_d = fetch_pc_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry_s),
    .rd_addr (rd_ptr_q),
    .rd_data (head_s)
  );

  assign bus.memAddress = fetch_pc_q;
  assign bus.memRequest = mem_request_s;
  assign bus.outValid   = out_valid_s;

  // Head outputs, masked to NOP / PC 0 while the queue is empty
  always_comb begin
    if (out_valid_s) begin
      bus.outInstruction    = head_s.instr;
      bus.outProgramCounter = head_s.pc;
    end else begin
      bus.outInstruction    = NOP_INSTR;
      bus.outProgramCounter = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, full-blocking, steady stream,
// memory stalls, flush redirect, PC wrap and asynchronous reset.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  flush;
  word_t flushTarget;
  int    n_cmp = 0;
  int    n_bad = 0;

  fetch_queue_if bus_if();

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .flushTarget (flushTarget),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  // Memory model: the word at each address is a fixed function of it
  function automatic word_t mem_word(input word_t pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  assign bus_if.memData = mem_word(bus_if.memAddress);

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic exp_valid, input word_t exp_pc,
                             input word_t exp_addr, input logic exp_req);
    check_eq({tag, ".valid"}, {31'd0, bus_if.outValid}, {31'd0, exp_valid});
    check_eq({tag, ".pc"}, bus_if.outProgramCounter, exp_valid ? exp_pc : 32'h0000_0000);
    check_eq({tag, ".instr"}, bus_if.outInstruction,
             exp_valid ? mem_word(exp_pc) : 32'h0000_0013);
    check_eq({tag, ".addr"}, bus_if.memAddress, exp_addr);
    check_eq({tag, ".req"}, {31'd0, bus_if.memRequest}, {31'd0, exp_req});
  endtask

  task automatic step(input logic succ, input logic rdy, input logic fl, input word_t tgt);
    bus_if.memSuccess    = succ;
    bus_if.consumerReady = rdy;
    flush                = fl;
    flushTarget          = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                  = 1'b1;
    flush                = 1'b0;
    flushTarget          = 32'h0000_0000;
    bus_if.memSuccess    = 1'b0;
    bus_if.consumerReady = 1'b0;
    #1;
    check_state("reset", 1'b0, 32'h0, 32'h0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill: four pushes, then full and the fetch address parks at 16
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check_state($sformatf("fill%0d", k), 1'b1, 32'h0,
                  (k < 4) ? word_t'(4 * k) : 32'h10, (k < 4));
    end

    // Full: pop without push, then the freed slot takes PC 16
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_state("full_pop", 1'b1, 32'h4, 32'h10, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_state("refill", 1'b1, 32'h4, 32'h14, 1'b0);

    // Drop to three entries, then stream one per cycle at constant count
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_state("drain1", 1'b1, 32'h8, 32'h14, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check_state($sformatf("steady%0d", k), 1'b1, word_t'(12 + 4 * k),
                  word_t'(24 + 4 * k), 1'b1);
    end

    // Flush with three queued and a successful fetch: word discarded
    step(1'b1, 1'b1, 1'b1, 32'h0000_0102);
    check_state("flush", 1'b0, 32'h0, 32'h100, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_state("post_flush", 1'b1, 32'h100, 32'h104, 1'b1);

    // Memory stall at address 8
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check_state("flush0", 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_state("pre_stall", 1'b1, 32'h0, 32'h8, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_state($sformatf("stall%0d", k), 1'b1, 32'h0, 32'h8, 1'b1);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_state("unstall", 1'b1, 32'h4, 32'hC, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_state("pop8", 1'b1, 32'h8, 32'hC, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_state("empty", 1'b0, 32'h0, 32'hC, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_state("empty_rdy", 1'b0, 32'h0, 32'hC, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_state("push12", 1'b1, 32'hC, 32'h10, 1'b1);

    // PC wrap at the top of the address space, unaligned target
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check_state("flush_top", 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_state("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_state("wrap2", 1'b1, 32'hFFFF_FFFC, 32'h4, 1'b1);

    // Asynchronous reset with two entries queued, checked before any edge
    rst = 1'b1;
    #1;
    check_state("rst_async", 1'b0, 32'h0, 32'h0, 1'b1);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_state("after_rst", 1'b1, 32'h0, 32'h4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
